// File: rtl/csi_pkg.sv
// Shared CSI-2 data-type codes and the packet sequencer state encoding.
package csi_pkg;

  localparam logic [5:0] CSI_DT_FS       = 6'h00;
  localparam logic [5:0] CSI_DT_FE       = 6'h01;
  localparam logic [5:0] CSI_DT_LS       = 6'h02;
  localparam logic [5:0] CSI_DT_LE       = 6'h03;
  localparam logic [5:0] CSI_DT_LONG_MIN = 6'h10;
  localparam logic [5:0] CSI_DT_RAW8     = 6'h2A;
  localparam logic [5:0] CSI_DT_RAW10    = 6'h2B;

  typedef enum logic [2:0] {
    IDLE,
    HDR1,
    PAYLOAD,
    CRC,
    WAIT_END
  } csi_state_e;

endpackage

// File: rtl/csi_header_decode.sv
// Classifies a CSI-2 packet header from its data type and word-count bytes.
// Purely combinational: zero latency, no backpressure.
module csi_header_decode
  import csi_pkg::*;
#(
  parameter logic [5:0] PIXEL_DT = CSI_DT_RAW10
) (
  input  logic [5:0]  dt,
  input  logic [7:0]  wc_lo,
  input  logic [7:0]  wc_hi,
  output logic        is_short,
  output logic        is_fs,
  output logic        is_fe,
  output logic        dt_match,
  output logic [15:0] wc
);

  assign is_short = (dt < CSI_DT_LONG_MIN);
  assign is_fs    = is_short && (dt == CSI_DT_FS);
  assign is_fe    = is_short && (dt == CSI_DT_FE);
  assign dt_match = (dt == PIXEL_DT);
  assign wc       = {wc_hi, wc_lo};

endmodule

// File: rtl/csi_packet_ctrl.sv
// CSI-2 packet sequencer: header parse, payload forwarding with CRC strip, frame/line tracking.
// 1-cycle registered output latency; no stall path, a beat offered while tready is low is lost and flagged.
module csi_packet_ctrl
  import csi_pkg::*;
#(
  parameter int         N_DATA_LANES = 2,
  parameter logic [5:0] PIXEL_DT     = CSI_DT_RAW10
) (
  input  logic                        rxbyteclkhs,
  input  logic                        rxbyteclkhs_reset,
  input  logic                        rxactivehs,
  input  logic [8*N_DATA_LANES-1:0]   word_in,
  input  logic                        word_valid,
  output logic                        m_axis_tvalid,
  output logic [8*N_DATA_LANES-1:0]   m_axis_tdata,
  output logic [N_DATA_LANES-1:0]     m_axis_tstrb,
  output logic                        m_axis_tlast,
  output logic                        m_axis_tuser,
  input  logic                        m_axis_tready,
  output logic                        in_frame,
  output logic [15:0]                 line_count,
  output logic                        err_overflow,
  output logic                        err_truncated,
  input  logic                        err_clear
);

  csi_state_e  state, state_nxt;
  logic [5:0]  dt_q;
  logic [7:0]  wc_lo_q;
  logic [15:0] rem;
  logic        fwd;
  logic        tuser_pend;

  logic        hdr_done, beat, trunc;
  logic        is_short, is_fs, is_fe, dt_match;
  logic [15:0] wc;
  logic        last_beat;
  logic [15:0] step;

  csi_header_decode #(.PIXEL_DT(PIXEL_DT)) u_hdr (
    .dt       (dt_q),
    .wc_lo    (wc_lo_q),
    .wc_hi    (word_in[7:0]),
    .is_short (is_short),
    .is_fs    (is_fs),
    .is_fe    (is_fe),
    .dt_match (dt_match),
    .wc       (wc)
  );

  assign last_beat = (rem <= 16'd2);
  assign step      = last_beat ? rem : 16'd2;

  // Truncation takes priority over a word arriving in the same cycle.
  always_comb begin
    state_nxt = state;
    hdr_done  = 1'b0;
    beat      = 1'b0;
    trunc     = 1'b0;
    case (state)
      IDLE:
        if (word_valid && rxactivehs) state_nxt = HDR1;
      HDR1:
        if (!rxactivehs) begin
          trunc     = 1'b1;
          state_nxt = IDLE;
        end else if (word_valid) begin
          hdr_done = 1'b1;
          if (is_short)          state_nxt = WAIT_END;
          else if (wc == 16'd0)  state_nxt = CRC;
          else                   state_nxt = PAYLOAD;
        end
      PAYLOAD:
        if (!rxactivehs) begin
          trunc     = 1'b1;
          state_nxt = IDLE;
        end else if (word_valid) begin
          beat = 1'b1;
          if (last_beat) state_nxt = CRC;
        end
      CRC:
        if (!rxactivehs) begin
          trunc     = 1'b1;
          state_nxt = IDLE;
        end else if (word_valid) begin
          state_nxt = WAIT_END;
        end
      WAIT_END:
        if (!rxactivehs) state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rxbyteclkhs or posedge rxbyteclkhs_reset) begin
    if (rxbyteclkhs_reset) begin
      state         <= IDLE;
      dt_q          <= '0;
      wc_lo_q       <= '0;
      rem           <= '0;
      fwd           <= 1'b0;
      tuser_pend    <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tstrb  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;
      in_frame      <= 1'b0;
      line_count    <= '0;
      err_overflow  <= 1'b0;
      err_truncated <= 1'b0;
    end else begin
      state         <= state_nxt;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tuser  <= 1'b0;

      if (state == IDLE && word_valid && rxactivehs) begin
        dt_q    <= word_in[5:0];
        wc_lo_q <= word_in[15:8];
      end

      if (hdr_done) begin
        rem <= wc;
        fwd <= !is_short && dt_match && in_frame;
        if (is_fs) begin
          in_frame   <= 1'b1;
          line_count <= '0;
          tuser_pend <= 1'b1;
        end
        if (is_fe) in_frame <= 1'b0;
      end

      if (beat) begin
        rem <= rem - step;
        if (fwd) begin
          m_axis_tvalid <= 1'b1;
          m_axis_tdata  <= word_in;
          m_axis_tstrb  <= (rem == 16'd1) ? 2'b01 : 2'b11;
          m_axis_tlast  <= last_beat;
          m_axis_tuser  <= tuser_pend;
          tuser_pend    <= 1'b0;
          if (last_beat && line_count != 16'hFFFF) line_count <= line_count + 16'd1;
        end
      end

      // A new error event in the same cycle as a clear leaves the flag set.
      err_overflow  <= (err_overflow && !err_clear) || (m_axis_tvalid && !m_axis_tready);
      err_truncated <= (err_truncated && !err_clear) || trunc;
    end
  end

endmodule

// File: doc/csi_packet_ctrl.md
Name: csi_packet_ctrl

Overview:
- Sequences CSI-2 packet reception for the 2-lane receiver. Sits between the word aligner (16-bit aligned words) and the AXI video stream output.
- Parses the 4-byte packet header and classifies short and long packets. Counts payload bytes, strips the CRC footer, and drives tlast/tuser/tstrb.
- Tracks frame and line state and reports protocol errors as status.

Parameters:
- N_DATA_LANES, 2, number of data lanes; only 2 is supported (word = 2 bytes: lane0 in [7:0], lane1 in [15:8]).
- PIXEL_DT, 6'h2B, long-packet data type forwarded to the stream (RAW10); other long packets are consumed and dropped.

Ports:
- rxbyteclkhs  in  1  byte clock; all logic is on this clock.
- rxbyteclkhs_reset  in  1  asynchronous, active-high reset.
- rxactivehs  in  1  AND of all lanes' rxactivehs; low = between packets.
- word_in  in  16  aligned word from the aligner.
- word_valid  in  1  word_in valid this cycle.
- m_axis_tvalid  out  1  payload word valid.
- m_axis_tdata  out  16  payload bytes.
- m_axis_tstrb  out  2  byte strobes.
- m_axis_tlast  out  1  last payload word of a line.
- m_axis_tuser  out  1  first payload word of a frame.
- m_axis_tready  in  1  downstream ready.
- in_frame  out  1  high between frame start and frame end.
- line_count  out  16  long pixel packets since frame start.
- err_overflow  out  1  sticky: word dropped because tready was low.
- err_truncated  out  1  sticky: rxactivehs fell before payload+CRC complete.
- err_clear  in  1  synchronous clear of both sticky errors.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, counters 0.
- Header byte mapping:
  - word0[7:0] = DI, word0[15:8] = WC[7:0].
  - word1[7:0] = WC[15:8], word1[15:8] = ECC. ECC is not checked.
  - DT = DI[5:0].
- FSM (advances only on word_valid; holds on cycles with word_valid=0):
  - IDLE: first valid word with rxactivehs=1 latches DI and WC_lo -> HDR1.
  - HDR1: latch WC_hi and classify.
    - DT < 6'h10 (short packet): handle short packet -> WAIT_END.
    - Long packet with WC = 0 -> CRC.
    - Otherwise -> PAYLOAD, with rem = WC.
  - PAYLOAD: each word decrements rem by min(rem, 2). When rem <= 2 -> CRC.
  - CRC: consume one word, discard it -> WAIT_END.
  - WAIT_END: ignore words until rxactivehs = 0 -> IDLE.
- Short packets:
  - DT 0x00 (FS): in_frame = 1, line_count = 0, arm a pending-tuser flag.
  - DT 0x01 (FE): in_frame = 0.
  - DT 0x02/0x03 (line start/end): ignored.
- Forwarding: only when DT = PIXEL_DT and in_frame = 1. Non-matching long packets traverse the same states with no output.
- Output timing: registered, 1-cycle latency from the accepted payload word. tvalid is high for exactly one cycle per word; there is no buffering.
- tstrb = 2'b11, except the final word of an odd WC = 2'b01.
- tlast = 1 on the final payload word.
- tuser = 1 on the first forwarded word after FS; the pending flag then clears.
- line_count increments when the tlast word is emitted; it saturates at 16'hFFFF.
- Overflow: if tvalid=1 and tready=0, set err_overflow. The word is lost and the FSM does not stall.
- Truncation: rxactivehs = 0 in HDR1, PAYLOAD or CRC sets err_truncated and returns to IDLE. A pending tlast is not emitted. The partial line is not counted.
- rxactivehs = 0 in IDLE/WAIT_END is normal.
- Simultaneous err_clear and a new error event: set wins.
- FS while in_frame = 1: restart the frame (line_count = 0, tuser re-armed); no error.

Decomposition:
- Shared package csi_pkg holds:
  - CSI_DT_FS = 6'h00, CSI_DT_FE = 6'h01, CSI_DT_LS = 6'h02, CSI_DT_LE = 6'h03.
  - CSI_DT_LONG_MIN = 6'h10, CSI_DT_RAW8 = 6'h2A, CSI_DT_RAW10 = 6'h2B.
  - The FSM state enum (IDLE, HDR1, PAYLOAD, CRC, WAIT_END).
- One natural sub-module: csi_header_decode. Combinational: DI/WC bytes -> is_short, is_fs, is_fe, dt_match, wc.

Test Plan:
- FS short packet, then long DT 0x2B with WC = 4 (words 0x2211, 0x4433), CRC word, FE -> two beats: 0x2211 (tuser=1, tstrb=11), then 0x4433 (tlast=1); line_count = 1; in_frame rises then falls.
- Long packet WC = 5 inside a frame -> three beats; the last has tstrb = 01 and tlast = 1; the CRC word is not output.
- Long packet DT 0x12 with WC = 6 inside a frame -> no tvalid; FSM returns to IDLE after rxactivehs falls.
- rxactivehs drops after the 1st of 3 payload words -> err_truncated = 1, no tlast, line_count unchanged; next packet parses normally.
- tready = 0 during a 2-word line -> err_overflow = 1. err_clear pulse -> 0. err_clear asserted together with a new overflow -> stays 1.
- Gaps of word_valid = 0 between payload words and a second FS mid-frame -> identical output data; line_count resets to 0 and tuser re-asserts on the next line.
